// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port between video bursts and CPU words.
// Define ARB_STATS_EN to add the grant counters and worst-case CPU wait output.
module sdram_port_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 32,
    parameter int VID_BURST   = 8,
    parameter int MAX_VID_RUN = 4
) (
    input  logic                clk_sdram,
    input  logic                rst,
    input  logic                vid_req,
    input  logic                vid_urgent,
    input  logic [ADDR_W-1:0]   vid_addr,
    output logic                vid_ack,
    output logic                vid_rvalid,
    output logic [DATA_W-1:0]   vid_rdata,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wmask,
    output logic                cpu_done,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [7:0]          mem_len,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_ack,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_done
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]         stat_vid_grants,
    output logic [31:0]         stat_cpu_grants,
    output logic [31:0]         stat_cpu_wait_max
`endif
);

    localparam int RUN_W = $clog2(MAX_VID_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_VID_RUN);
    localparam logic [7:0] VID_LEN = 8'(VID_BURST - 1);

    typedef enum logic [2:0] {
        IDLE,
        VID_CMD,
        VID_DATA,
        CPU_CMD,
        CPU_DATA
    } state_t;

    state_t            state_q;
    logic [RUN_W-1:0]  run_cnt_q;
    logic [RUN_W-1:0]  run_cnt_d;
    logic [DATA_W-1:0] cap_q;
    logic              cap_vld_q;
    logic              vid_req_eff;
    logic              cpu_req_eff;
    logic              grant_vid;
    logic              grant_cpu;
    logic [DATA_W-1:0] last_rdata;
    logic              last_vld;

    // A requester may still hold its level during its own completion pulse.
    assign vid_req_eff = vid_req & ~vid_ack;
    assign cpu_req_eff = cpu_req & ~cpu_done;

    always_comb begin
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        if (state_q == IDLE) begin
            if (vid_req_eff && vid_urgent) begin
                grant_vid = 1'b1;
            end else if (cpu_req_eff &&
                         (run_cnt_q >= RUN_MAX || !vid_req_eff)) begin
                grant_cpu = 1'b1;
            end else if (vid_req_eff) begin
                grant_vid = 1'b1;
            end
        end
    end

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (grant_cpu) begin
            run_cnt_d = '0;
        end else if (grant_vid) begin
            if (!cpu_req_eff) begin
                run_cnt_d = '0;
            end else if (run_cnt_q != RUN_MAX) begin
                run_cnt_d = run_cnt_q + RUN_W'(1);
            end
        end
    end

    // Last read beat of the current CPU access, including this cycle's.
    always_comb begin
        last_vld   = cap_vld_q;
        last_rdata = cap_q;
        if (mem_rvalid) begin
            last_vld   = 1'b1;
            last_rdata = mem_rdata;
        end
    end

    always_ff @(posedge clk_sdram) begin
        if (rst) begin
            state_q    <= IDLE;
            run_cnt_q  <= '0;
            cap_q      <= '0;
            cap_vld_q  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_len    <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            vid_ack    <= 1'b0;
            vid_rvalid <= 1'b0;
            vid_rdata  <= '0;
            cpu_done   <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            run_cnt_q  <= run_cnt_d;
            vid_ack    <= 1'b0;
            vid_rvalid <= 1'b0;
            cpu_done   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cap_vld_q <= 1'b0;
                    if (grant_vid) begin
                        state_q   <= VID_CMD;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= vid_addr;
                        mem_len   <= VID_LEN;
                        mem_wdata <= '0;
                        mem_wmask <= '0;
                    end else if (grant_cpu) begin
                        state_q   <= CPU_CMD;
                        mem_req   <= 1'b1;
                        mem_we    <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_len   <= '0;
                        mem_wdata <= cpu_wdata;
                        mem_wmask <= cpu_wmask;
                    end
                end
                VID_CMD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        vid_ack <= 1'b1;
                        state_q <= mem_done ? IDLE : VID_DATA;
                    end
                end
                VID_DATA: begin
                    vid_rvalid <= mem_rvalid;
                    if (mem_rvalid) begin
                        vid_rdata <= mem_rdata;
                    end
                    if (mem_done) begin
                        state_q <= IDLE;
                    end
                end
                CPU_CMD, CPU_DATA: begin
                    cap_vld_q <= last_vld;
                    cap_q     <= last_rdata;
                    if (state_q == CPU_CMD && mem_ack) begin
                        mem_req <= 1'b0;
                        state_q <= CPU_DATA;
                    end
                    if (mem_done && (state_q == CPU_DATA || mem_ack)) begin
                        state_q  <= IDLE;
                        cpu_done <= 1'b1;
                        if (!mem_we && last_vld) begin
                            cpu_rdata <= last_rdata;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] wait_q;
    logic        cpu_waiting;

    assign cpu_waiting = cpu_req_eff &&
                         (state_q == IDLE || state_q == VID_CMD ||
                          state_q == VID_DATA);

    always_ff @(posedge clk_sdram) begin
        if (rst) begin
            wait_q            <= '0;
            stat_vid_grants   <= '0;
            stat_cpu_grants   <= '0;
            stat_cpu_wait_max <= '0;
        end else begin
            if (grant_vid) begin
                stat_vid_grants <= stat_vid_grants + 32'd1;
            end
            if (grant_cpu) begin
                stat_cpu_grants <= stat_cpu_grants + 32'd1;
                if (wait_q > stat_cpu_wait_max) begin
                    stat_cpu_wait_max <= wait_q;
                end
                wait_q <= '0;
            end else if (cpu_waiting) begin
                if (wait_q != 32'hFFFF_FFFF) begin
                    wait_q <= wait_q + 32'd1;
                end
            end else begin
                wait_q <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: requesters, controller model, monitors.
module tb_sdram_port_arbiter;

    localparam int ADDR_W      = 24;
    localparam int DATA_W      = 32;
    localparam int VID_BURST   = 8;
    localparam int MAX_VID_RUN = 4;

    logic              clk_sdram;
    logic              rst = 1'b1;
    logic              vid_req;
    logic              vid_urgent;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [3:0]        cpu_wmask;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_len;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
`ifdef ARB_STATS_EN
    logic [31:0]       stat_vid_grants;
    logic [31:0]       stat_cpu_grants;
    logic [31:0]       stat_cpu_wait_max;
`endif

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .VID_BURST(VID_BURST), .MAX_VID_RUN(MAX_VID_RUN)
    ) dut (
        .clk_sdram(clk_sdram), .rst(rst),
        .vid_req(vid_req), .vid_urgent(vid_urgent), .vid_addr(vid_addr),
        .vid_ack(vid_ack), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_len(mem_len), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_done(mem_done)
`ifdef ARB_STATS_EN
        ,
        .stat_vid_grants(stat_vid_grants),
        .stat_cpu_grants(stat_cpu_grants),
        .stat_cpu_wait_max(stat_cpu_wait_max)
`endif
    );

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        wmask;
    } cmd_t;

    cmd_t        exp_cmd_q[$];
    logic [31:0] exp_vid_q[$];
    logic [31:0] exp_cpu_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    int          m_ack_dly  = 2;
    int          m_cpu_dly  = 6;
    int          m_vid_dly  = 12;
    logic [31:0] m_cpu_word = '0;

    int          vid_target = 0;
    int          vid_acks   = 0;
    int          vid_mark   = 0;
    logic [23:0] vid_base   = '0;
    int          cpu_target = 0;
    int          cpu_dones  = 0;

    initial begin
        clk_sdram = 1'b0;
        forever #5 clk_sdram = ~clk_sdram;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_sdram);
        #1;
    endtask

    task automatic push_vid(input logic [23:0] a);
        exp_cmd_q.push_back('{we: 1'b0, addr: a, len: 8'(VID_BURST - 1),
                              wdata: '0, wmask: '0});
        for (int k = 0; k < VID_BURST; k++)
            exp_vid_q.push_back({8'h5A, a + 24'(k)});
    endtask

    task automatic push_cpu(input logic we, input logic [23:0] a,
                            input logic [31:0] wd, input logic [3:0] wm,
                            input logic [31:0] rd);
        exp_cmd_q.push_back('{we: we, addr: a, len: 8'd0,
                              wdata: wd, wmask: wm});
        exp_cpu_q.push_back(rd);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_cmd_q.size() != 0 || exp_vid_q.size() != 0 ||
                exp_cpu_q.size() != 0 || vid_acks < vid_target ||
                cpu_dones < cpu_target) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, 64'(n < budget), 64'd1);
        repeat (3) tick();
    endtask

    // Controller model: ack after m_ack_dly, read beats end with done.
    initial begin : mem_model
        bit          busy;
        int          cnt;
        int          done_at;
        int          first;
        logic        we_l;
        logic [7:0]  len_l;
        logic [23:0] base;
        busy = 0; cnt = 0; done_at = 0; first = 0;
        we_l = 0; len_l = 0; base = 0;
        mem_ack = 0; mem_rvalid = 0; mem_rdata = '0; mem_done = 0;
        forever begin
            @(negedge clk_sdram);
            mem_ack = 0; mem_rvalid = 0; mem_done = 0;
            if (rst) begin
                busy = 0;
            end else begin
                if (!busy && mem_req) begin
                    busy = 1; cnt = 0;
                    we_l = mem_we; len_l = mem_len; base = mem_addr;
                    done_at = (len_l == 0) ? m_cpu_dly : m_vid_dly;
                end
                if (busy) begin
                    if (cnt == m_ack_dly) mem_ack = 1;
                    first = done_at - int'(len_l);
                    if (!we_l && cnt >= first) begin
                        mem_rvalid = 1;
                        mem_rdata = (len_l == 0) ? m_cpu_word :
                                    {8'h5A, base + 24'(cnt - first)};
                    end
                    if (cnt == done_at) begin
                        mem_done = 1;
                        busy = 0;
                    end
                    cnt++;
                end
            end
        end
    end

    initial begin : vid_requester
        vid_req = 0; vid_addr = '0;
        forever begin
            @(negedge clk_sdram);
            if (vid_req && vid_ack) vid_acks++;
            vid_addr = vid_base + 24'((vid_acks - vid_mark) * VID_BURST);
            vid_req = !rst && (vid_acks < vid_target);
        end
    end

    initial begin : cpu_requester
        cpu_req = 0;
        forever begin
            @(negedge clk_sdram);
            if (cpu_done) cpu_dones++;
            cpu_req = !rst && (cpu_dones < cpu_target);
        end
    end

    initial begin : monitor
        logic req_prev;
        cmd_t e;
        logic [31:0] ev;
        req_prev = 0;
        forever begin
            @(negedge clk_sdram);
            if (mem_req && !req_prev) begin
                if (exp_cmd_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_cmd: got addr 0x%0h, expected none",
                             mem_addr);
                end else begin
                    e = exp_cmd_q.pop_front();
                    check("cmd_we", 64'(mem_we), 64'(e.we));
                    check("cmd_addr", 64'(mem_addr), 64'(e.addr));
                    check("cmd_len", 64'(mem_len), 64'(e.len));
                    if (e.we) begin
                        check("cmd_wdata", 64'(mem_wdata), 64'(e.wdata));
                        check("cmd_wmask", 64'(mem_wmask), 64'(e.wmask));
                    end
                end
            end
            req_prev = mem_req;
            if (vid_rvalid) begin
                if (exp_vid_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_vid_beat: got 0x%0h, expected none",
                             vid_rdata);
                end else begin
                    ev = exp_vid_q.pop_front();
                    check("vid_rdata", 64'(vid_rdata), 64'(ev));
                end
            end
            if (cpu_done) begin
                if (exp_cpu_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_cpu_done: got rdata 0x%0h, expected none",
                             cpu_rdata);
                end else begin
                    ev = exp_cpu_q.pop_front();
                    check("cpu_rdata", 64'(cpu_rdata), 64'(ev));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a0;
        int d0;
        int n;
        vid_urgent = 0; cpu_we = 0; cpu_addr = '0;
        cpu_wdata = '0; cpu_wmask = '0;
        rst = 1;
        repeat (3) tick();
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_len", 64'(mem_len), 64'd0);
        check("rst_mem_wmask", 64'(mem_wmask), 64'd0);
        check("rst_vid_ack", 64'(vid_ack), 64'd0);
        check("rst_vid_rvalid", 64'(vid_rvalid), 64'd0);
        check("rst_cpu_done", 64'(cpu_done), 64'd0);
        check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        rst = 0;
        tick();

        // single CPU read, ack at 2, done at 6
        m_ack_dly = 2; m_cpu_dly = 6; m_cpu_word = 32'hDEADBEEF;
        cpu_we = 0; cpu_addr = 24'h000100; cpu_wmask = 4'hF;
        push_cpu(1'b0, 24'h000100, '0, '0, 32'hDEADBEEF);
        cpu_target++;
        wait_idle("t1_cpu_read", 200);

        // zero-latency write leaves cpu_rdata alone
        m_ack_dly = 0; m_cpu_dly = 0;
        cpu_we = 1; cpu_addr = 24'h000101;
        cpu_wdata = 32'h11223344; cpu_wmask = 4'hF;
        push_cpu(1'b1, 24'h000101, 32'h11223344, 4'hF, 32'hDEADBEEF);
        cpu_target++;
        wait_idle("t1_zl_write", 200);

        // zero-latency read
        m_cpu_word = 32'h12345678;
        cpu_we = 0; cpu_addr = 24'h000102;
        push_cpu(1'b0, 24'h000102, '0, '0, 32'h12345678);
        cpu_target++;
        wait_idle("t1_zl_read", 200);

        // single video burst
        m_ack_dly = 2; m_cpu_dly = 6; m_vid_dly = 12;
        a0 = vid_acks; d0 = cpu_dones;
        vid_base = 24'h040000; vid_mark = vid_acks;
        push_vid(24'h040000);
        vid_target++;
        wait_idle("t2_vid", 300);
        check("t2_vid_ack_count", 64'(vid_acks - a0), 64'd1);
        check("t2_no_cpu_done", 64'(cpu_dones - d0), 64'd0);

        // continuous video, CPU gets in after 4 bursts; run count clears
        a0 = vid_acks;
        vid_base = 24'h050000; vid_mark = vid_acks;
        for (int i = 0; i < 4; i++) push_vid(24'h050000 + 24'(8 * i));
        push_cpu(1'b0, 24'h000200, '0, '0, 32'hA0A0A0A0);
        for (int i = 4; i < 9; i++) push_vid(24'h050000 + 24'(8 * i));
        push_cpu(1'b0, 24'h000204, '0, '0, 32'hB0B0B0B0);
        push_vid(24'h050000 + 24'(8 * 9));
        cpu_addr = 24'h000200; m_cpu_word = 32'hA0A0A0A0;
        vid_target += 10;
        cpu_target++;
        n = 0;
        while (vid_acks - a0 < 5 && n < 2000) begin tick(); n++; end
        check("t3_wait_v5", 64'(n < 2000), 64'd1);
        cpu_addr = 24'h000204; m_cpu_word = 32'hB0B0B0B0;
        cpu_target++;
        wait_idle("t3_fair", 3000);
        check("t3_vid_ack_count", 64'(vid_acks - a0), 64'd10);

        // urgent video starves CPU until urgent drops
        a0 = vid_acks;
        vid_base = 24'h060000; vid_mark = vid_acks;
        vid_urgent = 1;
        for (int i = 0; i < 6; i++) push_vid(24'h060000 + 24'(8 * i));
        push_cpu(1'b0, 24'h000300, '0, '0, 32'hC0C0C0C0);
        push_vid(24'h060000 + 24'(8 * 6));
        push_vid(24'h060000 + 24'(8 * 7));
        cpu_addr = 24'h000300; m_cpu_word = 32'hC0C0C0C0;
        vid_target += 8;
        cpu_target++;
        n = 0;
        while (vid_acks - a0 < 6 && n < 2000) begin tick(); n++; end
        check("t4_wait_v6", 64'(n < 2000), 64'd1);
        vid_urgent = 0;
        wait_idle("t4_urgent", 2000);

        // simultaneous requests: video first, then CPU
        vid_base = 24'h070000; vid_mark = vid_acks;
        push_vid(24'h070000);
        push_cpu(1'b0, 24'h000400, '0, '0, 32'hD0D0D0D0);
        cpu_addr = 24'h000400; m_cpu_word = 32'hD0D0D0D0;
        vid_target++;
        cpu_target++;
        wait_idle("t5_same_cycle", 500);

        // reset while the CPU access is in flight
        m_ack_dly = 1; m_cpu_dly = 20;
        d0 = cpu_dones;
        cpu_addr = 24'h000500;
        exp_cmd_q.push_back('{we: 1'b0, addr: 24'h000500, len: 8'd0,
                              wdata: '0, wmask: '0});
        cpu_target++;
        n = 0;
        while (mem_ack !== 1'b1 && n < 100) begin tick(); n++; end
        check("t6_wait_ack", 64'(n < 100), 64'd1);
        tick();
        rst = 1;
        cpu_target = cpu_dones;
        tick();
        check("t6_mem_req", 64'(mem_req), 64'd0);
        check("t6_cpu_done", 64'(cpu_done), 64'd0);
        check("t6_cpu_rdata", 64'(cpu_rdata), 64'd0);
        tick();
        rst = 0;
        repeat (25) tick();
        check("t6_no_done", 64'(cpu_dones - d0), 64'd0);

        m_ack_dly = 2; m_cpu_dly = 4;
        cpu_we = 1; cpu_addr = 24'h000600;
        cpu_wdata = 32'hCAFEF00D; cpu_wmask = 4'h3;
        push_cpu(1'b1, 24'h000600, 32'hCAFEF00D, 4'h3, 32'h0);
        cpu_target++;
        wait_idle("t6_write", 200);

        check("leftover", 64'(exp_cmd_q.size() + exp_vid_q.size() +
                              exp_cpu_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
